// File: rtl/alu_sequencer_if.sv
// Bus between the alu_sequencer and the instruction memory, ALU, register file and I/O strobes.
// master = sequencer side, slave = datapath/memory side.
interface alu_sequencer_if;
    logic        start;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        S;
    logic        Z;
    logic        V;
    logic        alu_e;
    logic [3:0]  alu_opcode;
    logic [3:0]  alu_d;
    logic [2:0]  rf_ra;
    logic [2:0]  rf_rb;
    logic [2:0]  rf_wa;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic [15:0] imm;
    logic        dmem_re;
    logic        dmem_we;
    logic        out_we;
    logic        halted;
    logic [2:0]  state;

    modport master (
        input  start, imem_data, S, Z, V,
        output imem_addr, alu_e, alu_opcode, alu_d, rf_ra, rf_rb, rf_wa, rf_we,
               wb_sel, imm, dmem_re, dmem_we, out_we, halted, state
    );

    modport slave (
        output start, imem_data, S, Z, V,
        input  imem_addr, alu_e, alu_opcode, alu_d, rf_ra, rf_rb, rf_wa, rf_we,
               wb_sel, imm, dmem_re, dmem_we, out_we, halted, state
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle control unit for the 16-bit processor: fetch/decode/execute sequencing,
// PC ownership and branch evaluation. All bus outputs are registered.
//
//  state  | meaning
//  IDLE   | waiting for start
//  FETCH  | imem_addr = pc presented to instruction memory
//  DECODE | instruction word valid on imem_data, captured into ir
//  EXEC   | ALU strobe, branch flags sampled
//  MEM    | data memory strobe
//  WB     | register/output write-back, pc update
//  HALT   | stopped until reset
module alu_sequencer #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input logic            clk,
    input logic            rst,
    alu_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q;
    logic [15:0] ir_q, ir_d;
    logic [15:0] imm_x;
    logic        taken_q;
    logic        branch_cond;
    logic        is_hlt;

    logic        alu_e_d, rf_we_d, out_we_d, dmem_re_d, dmem_we_d;
    logic [2:0]  ra_d, rb_d, wa_d;
    logic [1:0]  wb_sel_d;
    logic [3:0]  opcode_d, alu_d_d;
    logic [15:0] imm_d;
    logic        active;

    assign ir_d  = (state_q == DECODE) ? bus.imem_data : ir_q;
    assign imm_x = {{8{ir_q[7]}}, ir_q[7:0]};
    assign is_hlt = (ir_q[15:14] == 2'b11) && (ir_q[7:4] == 4'b1111);

    assign bus.imem_addr = pc_q;
    assign bus.state     = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = FETCH;
            FETCH:   state_d = DECODE;
            DECODE:  state_d = EXEC;
            EXEC:    state_d = is_hlt ? HALT : MEM;
            MEM:     state_d = WB;
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        branch_cond = 1'b0;
        if (ir_q[15:14] == 2'b10) begin
            if (ir_q[13:11] == 3'b100) begin
                branch_cond = 1'b1;
            end else if (ir_q[13:11] == 3'b111) begin
                case (ir_q[10:8])
                    3'b000:  branch_cond = bus.Z;
                    3'b001:  branch_cond = bus.S ^ bus.V;
                    3'b010:  branch_cond = bus.Z | (bus.S ^ bus.V);
                    3'b011:  branch_cond = !bus.Z;
                    default: branch_cond = 1'b0;
                endcase
            end
        end
    end

    // Outputs are decoded from the upcoming state and instruction so the registers
    // line up with the state they belong to; fields are zero outside EXEC..WB.
    always_comb begin
        active    = (state_d == EXEC) || (state_d == MEM) || (state_d == WB);
        alu_e_d   = 1'b0;
        rf_we_d   = 1'b0;
        out_we_d  = 1'b0;
        dmem_re_d = 1'b0;
        dmem_we_d = 1'b0;
        ra_d      = 3'd0;
        rb_d      = 3'd0;
        wa_d      = 3'd0;
        wb_sel_d  = 2'b00;
        opcode_d  = 4'd0;
        alu_d_d   = 4'd0;
        imm_d     = 16'd0;
        if (active) begin
            opcode_d = ir_d[7:4];
            alu_d_d  = ir_d[3:0];
            imm_d    = {{8{ir_d[7]}}, ir_d[7:0]};
            case (ir_d[15:14])
                2'b11: begin
                    ra_d     = ir_d[10:8];
                    rb_d     = ir_d[13:11];
                    wa_d     = ir_d[10:8];
                    alu_e_d  = (state_d == EXEC) &&
                               !(ir_d[7:4] inside {4'b0111, 4'b1110, 4'b1111});
                    rf_we_d  = (state_d == WB) &&
                               (ir_d[7:4] inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                                                  4'b0110, 4'b1000, 4'b1001, 4'b1010, 4'b1011,
                                                  4'b1100});
                    out_we_d = (state_d == WB) && (ir_d[7:4] == 4'b1101);
                end
                2'b00: begin
                    rb_d      = ir_d[10:8];
                    wa_d      = ir_d[13:11];
                    wb_sel_d  = 2'b01;
                    dmem_re_d = (state_d == MEM);
                    rf_we_d   = (state_d == WB);
                end
                2'b01: begin
                    ra_d      = ir_d[13:11];
                    rb_d      = ir_d[10:8];
                    dmem_we_d = (state_d == MEM);
                end
                default: begin
                    if (ir_d[13:11] == 3'b000) begin
                        wa_d     = ir_d[10:8];
                        wb_sel_d = 2'b10;
                        rf_we_d  = (state_d == WB);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= PC_RESET;
            ir_q    <= 16'd0;
            taken_q <= 1'b0;
        end else begin
            ir_q <= ir_d;
            if (state_q == EXEC) taken_q <= branch_cond;
            if (state_q == WB)   pc_q    <= pc_q + 16'd1 + (taken_q ? imm_x : 16'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.alu_e      <= 1'b0;
            bus.alu_opcode <= 4'd0;
            bus.alu_d      <= 4'd0;
            bus.rf_ra      <= 3'd0;
            bus.rf_rb      <= 3'd0;
            bus.rf_wa      <= 3'd0;
            bus.rf_we      <= 1'b0;
            bus.wb_sel     <= 2'b00;
            bus.imm        <= 16'd0;
            bus.dmem_re    <= 1'b0;
            bus.dmem_we    <= 1'b0;
            bus.out_we     <= 1'b0;
            bus.halted     <= 1'b0;
        end else begin
            bus.alu_e      <= alu_e_d;
            bus.alu_opcode <= opcode_d;
            bus.alu_d      <= alu_d_d;
            bus.rf_ra      <= ra_d;
            bus.rf_rb      <= rb_d;
            bus.rf_wa      <= wa_d;
            bus.rf_we      <= rf_we_d;
            bus.wb_sel     <= wb_sel_d;
            bus.imm        <= imm_d;
            bus.dmem_re    <= dmem_re_d;
            bus.dmem_we    <= dmem_we_d;
            bus.out_we     <= out_we_d;
            bus.halted     <= (state_d == HALT);
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a table of single instructions run through
// FETCH..WB, plus hand-written HLT and reset-during-EXEC sequences.
module tb_alu_sequencer;

    logic clk = 1'b0;
    logic rst;

    alu_sequencer_if bus ();

    alu_sequencer #(.PC_RESET(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic        s, z, v;
        logic        ae, rwe, owe, re, we;
        logic [2:0]  ra, rb, wa;
        logic [1:0]  wb;
        logic        tk;
    } vec_t;

    localparam int NV = 19;
    vec_t        vecs [NV];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_pc;

    task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL [%0d] %s: got %0h expected %0h", idx, name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t        t;
        logic [15:0] sext;
        t    = vecs[i];
        sext = {{8{t.instr[7]}}, t.instr[7:0]};
        chk(i, "fetch state", 32'(bus.state), 32'd1);
        chk(i, "imem_addr", 32'(bus.imem_addr), 32'(exp_pc));
        bus.imem_data = t.instr;
        bus.S = t.s;
        bus.Z = t.z;
        bus.V = t.v;
        @(negedge clk);
        chk(i, "decode state", 32'(bus.state), 32'd2);
        chk(i, "decode alu_e", 32'(bus.alu_e), 32'd0);
        @(negedge clk);
        chk(i, "exec state", 32'(bus.state), 32'd3);
        chk(i, "exec alu_e", 32'(bus.alu_e), 32'(t.ae));
        chk(i, "exec opcode", 32'(bus.alu_opcode), 32'(t.instr[7:4]));
        chk(i, "exec alu_d", 32'(bus.alu_d), 32'(t.instr[3:0]));
        chk(i, "exec imm", 32'(bus.imm), 32'(sext));
        chk(i, "exec rf_ra", 32'(bus.rf_ra), 32'(t.ra));
        chk(i, "exec rf_rb", 32'(bus.rf_rb), 32'(t.rb));
        chk(i, "exec rf_we", 32'(bus.rf_we), 32'd0);
        chk(i, "exec dmem_re", 32'(bus.dmem_re), 32'd0);
        @(negedge clk);
        chk(i, "mem state", 32'(bus.state), 32'd4);
        chk(i, "mem alu_e", 32'(bus.alu_e), 32'd0);
        chk(i, "mem dmem_re", 32'(bus.dmem_re), 32'(t.re));
        chk(i, "mem dmem_we", 32'(bus.dmem_we), 32'(t.we));
        chk(i, "mem rf_we", 32'(bus.rf_we), 32'd0);
        @(negedge clk);
        chk(i, "wb state", 32'(bus.state), 32'd5);
        chk(i, "wb rf_we", 32'(bus.rf_we), 32'(t.rwe));
        chk(i, "wb out_we", 32'(bus.out_we), 32'(t.owe));
        chk(i, "wb rf_wa", 32'(bus.rf_wa), 32'(t.wa));
        chk(i, "wb wb_sel", 32'(bus.wb_sel), 32'(t.wb));
        chk(i, "wb rf_ra", 32'(bus.rf_ra), 32'(t.ra));
        chk(i, "wb dmem_we", 32'(bus.dmem_we), 32'd0);
        exp_pc = t.tk ? (exp_pc + 16'd1 + sext) : (exp_pc + 16'd1);
        @(negedge clk);
        chk(i, "next imem_addr", 32'(bus.imem_addr), 32'(exp_pc));
        chk(i, "next rf_we", 32'(bus.rf_we), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          instr    S     Z     V     ae    rwe   owe   re    we    ra    rb    wa    wb     tk
        vecs[0]  = '{16'hD100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd2, 3'd1, 2'b00, 1'b0};
        vecs[1]  = '{16'hE350, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd4, 3'd3, 2'b00, 1'b0};
        vecs[2]  = '{16'hC5D0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 3'd0, 3'd5, 2'b00, 1'b0};
        vecs[3]  = '{16'hC070, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0};
        vecs[4]  = '{16'h8680, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd6, 2'b10, 1'b0};
        vecs[5]  = '{16'hB8FD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b1};
        vecs[6]  = '{16'hB8FD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0};
        vecs[7]  = '{16'hB902, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b1};
        vecs[8]  = '{16'hBA10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0};
        vecs[9]  = '{16'hBB05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b1};
        vecs[10] = '{16'hA0FE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b1};
        vecs[11] = '{16'hBF05, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0};
        vecs[12] = '{16'h1500, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd5, 3'd2, 2'b01, 1'b0};
        vecs[13] = '{16'h5C00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 3'd4, 3'd0, 2'b00, 1'b0};
        vecs[14] = '{16'hC1C0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 3'd1, 2'b00, 1'b0};
        vecs[15] = '{16'hFFE3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 3'd7, 3'd7, 2'b00, 1'b0};
        vecs[16] = '{16'hBB05, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0};
        vecs[17] = '{16'hA0EB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b1};
        vecs[18] = '{16'h8800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0};

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.imem_data = 16'h0000;
        bus.S         = 1'b0;
        bus.Z         = 1'b0;
        bus.V         = 1'b0;
        exp_pc        = 16'h0000;

        repeat (2) @(negedge clk);
        chk(-1, "rst state", 32'(bus.state), 32'd0);
        chk(-1, "rst imem_addr", 32'(bus.imem_addr), 32'h0);
        chk(-1, "rst alu_e", 32'(bus.alu_e), 32'd0);
        chk(-1, "rst halted", 32'(bus.halted), 32'd0);
        chk(-1, "rst wb_sel", 32'(bus.wb_sel), 32'd0);
        chk(-1, "rst imm", 32'(bus.imm), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk(-1, "idle hold state", 32'(bus.state), 32'd0);
        chk(-1, "idle wb_sel", 32'(bus.wb_sel), 32'd0);
        chk(-1, "idle rf_we", 32'(bus.rf_we), 32'd0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i);

        // HLT from FETCH at pc 0
        chk(-2, "hlt fetch state", 32'(bus.state), 32'd1);
        chk(-2, "hlt imem_addr", 32'(bus.imem_addr), 32'(exp_pc));
        bus.imem_data = 16'hC0F0;
        @(negedge clk);
        @(negedge clk);
        chk(-2, "hlt exec alu_e", 32'(bus.alu_e), 32'd0);
        chk(-2, "hlt exec halted", 32'(bus.halted), 32'd0);
        @(negedge clk);
        chk(-2, "hlt state", 32'(bus.state), 32'd6);
        chk(-2, "hlt halted", 32'(bus.halted), 32'd1);
        chk(-2, "hlt alu_e", 32'(bus.alu_e), 32'd0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk(-2, "hlt after start state", 32'(bus.state), 32'd6);
        chk(-2, "hlt after start halted", 32'(bus.halted), 32'd1);
        chk(-2, "hlt pc unchanged", 32'(bus.imem_addr), 32'(exp_pc));
        chk(-2, "hlt rf_we", 32'(bus.rf_we), 32'd0);

        rst = 1'b1;
        #1;
        chk(-3, "rst from halt state", 32'(bus.state), 32'd0);
        chk(-3, "rst from halt halted", 32'(bus.halted), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        exp_pc = 16'h0000;

        // ADD interrupted by reset in EXEC
        chk(-4, "add2 fetch", 32'(bus.state), 32'd1);
        bus.imem_data = 16'hD100;
        @(negedge clk);
        @(negedge clk);
        chk(-4, "add2 exec alu_e", 32'(bus.alu_e), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk(-4, "async alu_e drop", 32'(bus.alu_e), 32'd0);
        chk(-4, "async state idle", 32'(bus.state), 32'd0);
        chk(-4, "async pc reset", 32'(bus.imem_addr), 32'h0000);
        chk(-4, "async rf_ra", 32'(bus.rf_ra), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk(-4, "rst hold rf_we", 32'(bus.rf_we), 32'd0);
            chk(-4, "rst hold state", 32'(bus.state), 32'd0);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk(-4, "post rst idle", 32'(bus.state), 32'd0);
        chk(-4, "post rst rf_we", 32'(bus.rf_we), 32'd0);
        chk(-4, "post rst pc", 32'(bus.imem_addr), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
